result_readout: RTL and testbench

Drain engine at the output end of the vector-multiply datapath. After a run has written partial-sum rows into the results SRAM, this block reads a programmed range of rows back and serialises each row's MATRIX_SIZE signed lanes onto a single-lane valid/ready stream for the host or a downstream consumer. It owns the SRAM read port: address, read enable and one-cycle read latency.

---
 rtl/result_readout_if.sv | 31 +++
 rtl/result_readout.sv | 130 +++++++++++++
 tb/tb_result_readout.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/result_readout_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_readout_if : results-SRAM read port plus single-lane result stream |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface result_readout_if #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int LANE_BW        = $clog2(MATRIX_SIZE)
);
  logic                                  sram_read_enable;
  logic [ADDRESSSIZE-1:0]                sram_address;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_in;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [PARTIAL_SUM_BW-1:0]             out_data;
  logic [LANE_BW-1:0]                    out_lane;
  logic                                  out_last;

  modport master (
    output sram_read_enable, sram_address, out_valid, out_data, out_lane, out_last,
    input  sram_data_in, out_ready
  );

  modport slave (
    input  sram_read_enable, sram_address, out_valid, out_data, out_lane, out_last,
    output sram_data_in, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/result_readout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_readout : drains a range of results-SRAM rows onto a lane stream  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module result_readout #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int LANE_BW        = $clog2(MATRIX_SIZE)
) (
  input  wire                   clk,
  input  wire                   rstn,
  input  wire                   start,
  input  wire [ADDRESSSIZE-1:0] base_address,
  input  wire [ADDRESSSIZE-1:0] row_count,
  output logic                  busy,
  output logic                  done,
  result_readout_if.master      bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [LANE_BW-1:0]     LAST_LANE = LANE_BW'(MATRIX_SIZE - 1);
  localparam logic [ADDRESSSIZE-1:0] ONE_ROW   = ADDRESSSIZE'(1);

  state_t                                state;
  state_t                                state_next;
  logic [ADDRESSSIZE-1:0]                row_base;
  logic [ADDRESSSIZE-1:0]                total_rows;
  logic [ADDRESSSIZE-1:0]                row;
  logic [ADDRESSSIZE-1:0]                row_inc;
  logic [LANE_BW-1:0]                    lane;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_buf;
  logic [PARTIAL_SUM_BW-1:0]             lane_word [MATRIX_SIZE];
  logic                                  in_send;
  logic                                  last_lane;

  genvar g;
  generate
    for (g = 0; g < MATRIX_SIZE; g++) begin : g_lane_view
      assign lane_word[g] = row_buf[g*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end
  endgenerate

  assign in_send   = (state == SEND);
  assign last_lane = (lane == LAST_LANE);
  assign row_inc   = row + ONE_ROW;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (row_count == '0) ? DONE : REQ;
        end
      end
      REQ:     state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND: begin
        if (bus.out_ready && last_lane) begin
          state_next = (row_inc < total_rows) ? REQ : DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters and the row buffer only move in the state that owns them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_base   <= '0;
      total_rows <= '0;
      row        <= '0;
      lane       <= '0;
      row_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_base   <= base_address;
            total_rows <= row_count;
            row        <= '0;
          end
        end
        CAPTURE: begin
          row_buf <= bus.sram_data_in;
          lane    <= '0;
        end
        SEND: begin
          if (bus.out_ready) begin
            lane <= lane + 1'b1;
            if (last_lane) begin
              row <= row_inc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Address addition wraps naturally at the SRAM boundary.
  assign bus.sram_read_enable = (state == REQ);
  assign bus.sram_address     = (state == REQ) ? (row_base + row) : '0;
  assign bus.out_valid        = in_send;
  assign bus.out_data         = in_send ? lane_word[lane] : '0;
  assign bus.out_lane         = in_send ? lane : '0;
  assign bus.out_last         = in_send && last_lane && (row == total_rows - ONE_ROW);
  assign busy                 = (state != IDLE);
  assign done                 = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_result_readout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_result_readout : randomized self-checking bench for result_readout    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_result_readout;
  localparam int AW = 10;
  localparam int PW = 20;
  localparam int MS = 8;
  localparam int LW = 3;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] row_count;
  logic          busy;
  logic          done;

  int vectors    = 0;
  int miscompares = 0;

  logic [PW-1:0] lanes_mem [1024][MS];

  result_readout_if #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PW), .MATRIX_SIZE(MS)) bus ();

  result_readout #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PW), .MATRIX_SIZE(MS)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_address (base_address),
    .row_count    (row_count),
    .busy         (busy),
    .done         (done),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW*MS-1:0] pack_row(input logic [AW-1:0] a);
    logic [PW*MS-1:0] w;
    w = '0;
    for (int l = 0; l < MS; l++) w[l*PW +: PW] = lanes_mem[a][l];
    return w;
  endfunction

  // One-cycle-latency SRAM read port
  always @(posedge clk) begin
    if (bus.sram_read_enable) bus.sram_data_in <= pack_row(bus.sram_address);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return ($urandom % 4) != 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_re"},    bus.sram_read_enable, 0);
    check({tag, "_addr"},  bus.sram_address, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_data"},  bus.out_data, 0);
    check({tag, "_lane"},  bus.out_lane, 0);
    check({tag, "_last"},  bus.out_last, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
  endtask

  // Expected beats and read addresses come straight from the row/lane layout.
  task automatic run_transfer(input int base_a, input int n, input int mode,
                              input int exp_done, input int extra_start);
    logic [PW-1:0] exp_q[$];
    int            exp_addr[$];
    int            cyc, done_cyc, beats, reads, stalls, first_valid, first_read;
    logic          prev_stall;
    logic [PW-1:0] prev_data;
    logic [LW-1:0] prev_lane;
    int            model_done;

    for (int r = 0; r < n; r++) begin
      exp_addr.push_back((base_a + r) % 1024);
      for (int l = 0; l < MS; l++) exp_q.push_back(lanes_mem[(base_a + r) % 1024][l]);
    end

    @(negedge clk);
    start        = 1'b1;
    base_address = AW'(base_a);
    row_count    = AW'(n);
    bus.out_ready = ready_for(mode, 0);
    cyc = 0; done_cyc = -1; beats = 0; reads = 0; stalls = 0;
    first_valid = -1; first_read = -1; prev_stall = 1'b0;
    prev_data = '0; prev_lane = '0;

    while (done_cyc < 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_start);
      if (start) begin
        base_address = AW'($urandom);
        row_count    = AW'($urandom_range(1, 50));
      end
      bus.out_ready = ready_for(mode, cyc);
      check("busy", busy, 1);
      if (bus.sram_read_enable) begin
        if (first_read < 0) first_read = cyc;
        if (reads < exp_addr.size()) check("rd_addr", bus.sram_address, exp_addr[reads]);
        else check("extra_read", 1, 0);
        reads++;
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
          check("hold_data", bus.out_data, prev_data);
          check("hold_lane", bus.out_lane, prev_lane);
        end
        check("last_flag", bus.out_last, beats == exp_q.size() - 1);
        if (beats < exp_q.size()) begin
          check("beat_data", bus.out_data, exp_q[beats]);
          check("beat_lane", bus.out_lane, beats % MS);
        end else begin
          check("extra_beat", 1, 0);
        end
        if (bus.out_ready) begin
          beats++;
          prev_stall = 1'b0;
        end else begin
          stalls++;
          prev_stall = 1'b1;
          prev_data  = bus.out_data;
          prev_lane  = bus.out_lane;
        end
      end else begin
        check("last_idle", bus.out_last, 0);
        prev_stall = 1'b0;
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;

    model_done = (n == 0) ? 1 : 10 * n + 1 + stalls;
    check("done_cycle", done_cyc, model_done);
    if (exp_done >= 0) check("done_plan", done_cyc, exp_done);
    check("beats", beats, exp_q.size());
    check("reads", reads, n);
    if (n > 0) begin
      check("first_read", first_read, 1);
      check("first_valid", first_valid, 3);
    end

    @(negedge clk);
    check("done_pulse", done, 0);
    check("back_idle", busy, 0);
    if (extra_start >= 0) begin
      repeat (3) begin
        @(negedge clk);
        check("no_requeue_busy", busy, 0);
        check("no_requeue_re", bus.sram_read_enable, 0);
      end
    end
  endtask

  task automatic abort_test();
    for (int r = 0; r < 3; r++)
      for (int l = 0; l < MS; l++) lanes_mem[5 + r][l] = PW'($urandom);
    @(negedge clk);
    start = 1'b1; base_address = AW'(5); row_count = AW'(3); bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_abort_valid", bus.out_valid, 1);
    check("pre_abort_lane", bus.out_lane, 1);
    check("pre_abort_data", bus.out_data, lanes_mem[6][1]);
    #2 rstn = 1'b0;
    #1 check_idle_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_busy", busy, 0);
    end
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base_address = '0; row_count = '0;
    bus.out_ready = 1'b0;
    bus.sram_data_in = '0;
    for (int a = 0; a < 1024; a++)
      for (int l = 0; l < MS; l++) lanes_mem[a][l] = '0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;

    for (int l = 0; l < 7; l++) lanes_mem[0][l] = PW'(l + 1);
    lanes_mem[0][7] = 20'hFFFFB;
    run_transfer(0, 1, 0, 11, -1);
    run_transfer(0, 1, 1, 19, -1);

    for (int r = 0; r < 8; r++)
      for (int l = 0; l < MS; l++) lanes_mem[r][l] = PW'(r * 16 + l);
    run_transfer(0, 8, 0, 81, -1);

    for (int l = 0; l < MS; l++) begin
      lanes_mem[1023][l] = PW'($urandom);
      lanes_mem[0][l]    = PW'($urandom);
    end
    run_transfer(1023, 2, 0, 21, -1);
    run_transfer(0, 0, 0, 1, -1);

    abort_test();
    run_transfer(5, 3, 0, 31, 7);

    for (int t = 0; t < 6; t++) begin
      int b, n;
      b = (t == 0) ? 1021 : int'($urandom_range(0, 1023));
      n = $urandom_range(1, 4);
      for (int r = 0; r < n; r++)
        for (int l = 0; l < MS; l++) lanes_mem[(b + r) % 1024][l] = PW'($urandom);
      run_transfer(b, n, 2, -1, (t % 2 == 0) ? 4 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
